fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage for the 16-bit core.
//
// Owns the fetch PC. It issues one word read per cycle to a 1-cycle-latency
// instruction memory. Each returned word is buffered together with the PC it
// came from in a DEPTH-entry FIFO, and the FIFO drains to decode through a
// valid/ready handshake. A redirect flushes the queue and restarts fetch at
// redirect_pc.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a kept
// response that arrives while the queue is empty is presented to decode in
// the same cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/imem_addr  fetch request and word address
//   imem_rvalid/rdata   memory response, one cycle after the request
//   redirect/_pc        flush and restart fetch at redirect_pc
//   dec_valid/ready     head-entry handshake to decode
//   dec_instr/dec_pc    head instruction and its PC
//   count               occupied FIFO entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_rvalid,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [XLEN-1:0]        dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] FULL_OCC = (PW+2)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;

  state_t          state, state_nxt;
  entry_t          fifo [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [PW+1:0]   occ;
  logic            issue, kept, byp, pop, push, fifo_pop;

  // The in-flight request is counted as occupied, so a response always has
  // a free slot to land in.
  assign occ      = {1'b0, count} + {{(PW+1){1'b0}}, (state != IDLE)};
  assign issue    = !rst && !redirect && (occ < FULL_OCC);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // Responses are kept only in BUSY. A stray response in IDLE and the
  // response to a squashed fetch both fall through here.
  assign kept = imem_rvalid && (state == BUSY) && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp       = kept && (count == '0);
  assign dec_instr = byp ? imem_rdata : fifo[head].instr;
  assign dec_pc    = byp ? req_pc     : fifo[head].pc;
`else
  assign byp       = 1'b0;
  assign dec_instr = fifo[head].instr;
  assign dec_pc    = fifo[head].pc;
`endif

  assign dec_valid = ((count != '0) || byp) && !redirect;
  assign pop       = dec_valid && dec_ready;
  // A bypassed word that decode accepts never touches the FIFO.
  assign push      = kept && !(byp && dec_ready);
  assign fifo_pop  = pop && !byp;

  always_comb begin
    state_nxt = IDLE;
    if (redirect)   state_nxt = (state == BUSY) ? SQUASH : IDLE;
    else if (issue) state_nxt = BUSY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= redirect_pc;
      end else begin
        if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + XLEN'(1);
        end
        if (push) begin
          fifo[tail] <= {imem_rdata, req_pc};
          tail       <= tail + PW'(1);
        end
        if (fifo_pop) head <= head + PW'(1);
        if (push && !fifo_pop)      count <= count + (PW+1)'(1);
        else if (!push && fifo_pop) count <= count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. A 1-cycle memory returns addr ^ 0xA5A5. The
// reference model keeps the undelivered words as a queue of PCs, plus a
// single pending fetch. Each cycle it predicts the request, the head and
// the occupancy from those rules.
module tb_fetch_queue;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, redirect = 1'b0, dec_ready = 1'b0, spur = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req, imem_rvalid, dec_valid;
  logic [15:0] imem_addr, imem_rdata, dec_instr, dec_pc;
  logic [2:0]  count;
  logic        mem_rv = 1'b0;
  logic [15:0] mem_rd = '0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .count(count));

  always #5 clk = ~clk;

  // Memory: answers every request in the next cycle; spur injects a stray beat.
  always @(posedge clk) begin
    mem_rv <= imem_req;
    mem_rd <= imem_addr ^ 16'hA5A5;
  end
  assign imem_rvalid = mem_rv | spur;
  assign imem_rdata  = spur ? 16'hDEAD : mem_rd;

  // Reference model state.
  logic [15:0] mq[$];
  logic        m_pend;
  logic [15:0] m_pend_pc, m_fpc;
  logic        e_req, e_dv;
  logic [15:0] e_addr, e_pc, e_instr;
  int          e_cnt;
  logic [52:0] e_vec, o_vec;
  int          nchk = 0, npass = 0;
  logic [15:0] got[$];

  function automatic void model_reset();
    mq.delete();
    m_pend = 1'b0; m_pend_pc = '0; m_fpc = '0;
  endfunction

  // Predict this cycle's outputs and snapshot the DUT at the falling edge.
  task automatic sample();
    @(negedge clk);
    if (rst) begin
      e_req = 0; e_addr = 0; e_dv = 0; e_pc = 0; e_instr = 0; e_cnt = 0;
    end else begin
      e_req   = !redirect && (mq.size() + int'(m_pend)) < DEPTH;
      e_addr  = m_fpc;
      e_dv    = !redirect && (mq.size() != 0 || (BYP && m_pend));
      e_pc    = (mq.size() != 0) ? mq[0] : m_pend_pc;
      e_instr = e_pc ^ 16'hA5A5;
      e_cnt   = mq.size();
    end
    e_vec = {e_req, (e_req || rst) ? e_addr : 16'h0, e_dv,
             (e_dv || rst) ? {e_pc, e_instr} : 32'h0, 3'(e_cnt)};
    o_vec = {imem_req, (e_req || rst) ? imem_addr : 16'h0, dec_valid,
             (e_dv || rst) ? {dec_pc, dec_instr} : 32'h0, count};
    if (dec_valid && dec_ready && !rst) got.push_back(dec_pc);
  endtask

  // Apply what the coming clock edge does, then step to just after it.
  task automatic adv();
    if (rst) model_reset();
    else if (redirect) begin
      mq.delete(); m_pend = 1'b0; m_fpc = redirect_pc;
    end else begin
      // With the queue empty, a delivered word came straight from memory.
      if (!(e_dv && dec_ready && mq.size() == 0)) begin
        if (e_dv && dec_ready) void'(mq.pop_front());
        if (m_pend) mq.push_back(m_pend_pc);
      end
      m_pend = e_req;
      if (e_req) begin m_pend_pc = m_fpc; m_fpc = m_fpc + 16'd1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL reset c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
  endtask

  task automatic test_stream();
    int first = -1;
    rst = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL stream c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      if (dec_valid && first < 0) first = i;
      adv();
    end
    nchk++;
    if (first !== 2 - int'(BYP)) $display("FAIL first_valid got %0d exp %0d", first, 2 - int'(BYP));
    else npass++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; spur = 1'b0;
    sample(); adv();
    rst = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL bp_hold c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      if (i == 9) begin
        nchk++;
        if ({count, imem_req} !== {3'(DEPTH), 1'b0})
          $display("FAIL bp_full got cnt %0d req %b exp cnt %0d req 0", count, imem_req, DEPTH);
        else npass++;
      end
      adv();
    end
    dec_ready = 1'b1; got.delete();
    for (int i = 0; i < 8; i++) begin
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL bp_drain c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
    for (int k = 0; k < 5; k++) begin
      nchk++;
      if (got.size() <= k || got[k] !== 16'(k))
        $display("FAIL bp_order k%0d got %h exp %h", k, (got.size() > k) ? got[k] : 16'hxxxx, 16'(k));
      else npass++;
    end
  endtask

  task automatic test_redirect_flush();
    int first = -1;
    logic [15:0] fpc = 'x;
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      redirect = (i == 4); redirect_pc = 16'h0020;
      if (i == 5) dec_ready = 1'b1;
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL flush c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      if (i == 4) begin
        nchk++;
        if ({count, imem_rvalid} !== {3'd3, 1'b1})
          $display("FAIL flush_setup got cnt %0d rv %b exp cnt 3 rv 1", count, imem_rvalid);
        else npass++;
      end
      if (i > 4 && dec_valid && first < 0) begin first = i; fpc = dec_pc; end
      adv();
    end
    redirect = 1'b0;
    nchk++;
    if (first !== 7 - int'(BYP) || fpc !== 16'h0020)
      $display("FAIL flush_latency got c%0d pc %h exp c%0d pc 0020", first, fpc, 7 - int'(BYP));
    else npass++;
  endtask

  task automatic test_wrap();
    logic [15:0] ev;
    dec_ready = 1'b1; got.delete();
    for (int i = 0; i < 10; i++) begin
      redirect = (i == 0); redirect_pc = 16'hFFFE;
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL wrap c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ev = 16'hFFFE + 16'(k);
      nchk++;
      if (got.size() <= k || got[k] !== ev)
        $display("FAIL wrap_order k%0d got %h exp %h", k, (got.size() > k) ? got[k] : 16'hxxxx, ev);
      else npass++;
    end
  endtask

  task automatic test_spurious();
    do_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      spur = (i == 7 || i == 8) && !m_pend;
      if (i == 10) dec_ready = 1'b1;
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL spurious c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
    spur = 1'b0;
  endtask

  task automatic test_reset_mid();
    dec_ready = 1'b1;
    // Reset asserted mid-cycle with a fetch outstanding, held over an edge.
    for (int i = 0; i < 3; i++) begin sample(); adv(); end
    #1 rst = 1'b1;
    sample(); nchk++;
    if (o_vec !== e_vec) $display("FAIL mid_reset got %h exp %h", o_vec, e_vec);
    else npass++;
    adv();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL after_reset c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
    // A short pulse leaves the old response arriving after release.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL stale_resp c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      dec_ready   = ($urandom % 4) != 0;
      redirect    = ($urandom % 16) == 0;
      redirect_pc = 16'($urandom);
      spur        = !m_pend && (($urandom % 8) == 0);
      sample(); nchk++;
      if (o_vec !== e_vec) $display("FAIL random c%0d got %h exp %h", i, o_vec, e_vec);
      else npass++;
      adv();
    end
    redirect = 1'b0; spur = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
